// File: rtl/ram_sp_pkg.sv
// Shared types and constants for the parametrised single-port RAM.
// Optional feature macro: RAM_SP_OUT_REG_EN (adds an output pipeline stage,
// raising read latency from 1 to 2 cycles).
package ram_sp_pkg;

    // Controller states: zero-fill after reset, then normal service.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } ram_state_e;

    // Width of one byte lane gated by a single byte enable.
    localparam int unsigned BYTE_W = 8;

    // Read latency in clock edges from accepted request to dout/rvalid.
`ifdef RAM_SP_OUT_REG_EN
    localparam int unsigned RD_LAT = 2;
`else
    localparam int unsigned RD_LAT = 1;
`endif

endpackage : ram_sp_pkg

// File: rtl/ram_sp_array.sv
// Storage array for ram_sp_param: one shared address, one write port with
// per-byte enables and one synchronous read. The array itself has no reset;
// its contents are defined only by the clear sequence in the top level.
module ram_sp_array
    import ram_sp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [DATA_W/BYTE_W-1:0]   wr_be,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data
);

    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int NB_BYTES = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write: only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NB_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Synchronous read; the register holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule : ram_sp_array

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with per-byte write enables,
// request/ready handshake, read-valid strobe and a post-reset zero-fill
// sequencer. Optional macro RAM_SP_OUT_REG_EN adds an output pipeline stage
// on dout/rvalid (read latency 2 instead of 1).
module ram_sp_param
    import ram_sp_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    we,
    input  logic [DATA_W/8-1:0]     be,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       din,
    output logic                    ready,
    output logic [DATA_W-1:0]       dout,
    output logic                    rvalid
);

    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int NB_BYTES = DATA_W / 8;

    if ((DATA_W % BYTE_W) != 0) begin : g_bad_data_w
        $error("ram_sp_param: DATA_W (%0d) must be a multiple of 8", DATA_W);
    end

    ram_state_e              state;
    ram_state_e              state_next;
    logic [ADDR_W-1:0]       clr_addr;

    logic                    arr_wr_en;
    logic [NB_BYTES-1:0]     arr_wr_be;
    logic [ADDR_W-1:0]       arr_addr;
    logic [DATA_W-1:0]       arr_wr_data;
    logic                    arr_rd_en;
    logic [DATA_W-1:0]       arr_rd_data;

    logic                    rd_accept;
    logic                    rd_seen;
    logic                    rvalid_s1;
    logic [DATA_W-1:0]       dout_s1;

    // State register; reset always restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave clear after the last word has been written.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_CLEAR: begin
                if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // Clear address counter; wraps back to 0 as the last word is written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    // Outputs of the FSM: handshake plus the storage port mux between
    // clear writes and user accesses. Nothing touches the array on a reset edge.
    always_comb begin
        ready       = 1'b0;
        arr_wr_en   = 1'b0;
        arr_wr_be   = '0;
        arr_addr    = addr;
        arr_wr_data = din;
        arr_rd_en   = 1'b0;
        rd_accept   = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                arr_wr_en   = rst_n;
                arr_wr_be   = '1;
                arr_addr    = clr_addr;
                arr_wr_data = CLEAR_VAL;
            end
            ST_IDLE: begin
                ready       = 1'b1;
                arr_wr_en   = rst_n & req & we;
                arr_wr_be   = be;
                rd_accept   = rst_n & req & ~we;
                arr_rd_en   = rd_accept;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    ram_sp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_be   (arr_wr_be),
        .addr    (arr_addr),
        .wr_data (arr_wr_data),
        .rd_en   (arr_rd_en),
        .rd_data (arr_rd_data)
    );

    // The array read register has no reset, so dout is forced to zero until
    // the first read after reset; rvalid marks each freshly read word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_seen   <= 1'b0;
            rvalid_s1 <= 1'b0;
        end else begin
            rd_seen   <= rd_seen | rd_accept;
            rvalid_s1 <= rd_accept;
        end
    end

    assign dout_s1 = rd_seen ? arr_rd_data : '0;

`ifdef RAM_SP_OUT_REG_EN
    logic                    rvalid_s2;
    logic [DATA_W-1:0]       dout_s2;

    // Extra output stage; reset clears it together with the first stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_s2 <= 1'b0;
            dout_s2   <= '0;
        end else begin
            rvalid_s2 <= rvalid_s1;
            dout_s2   <= dout_s1;
        end
    end

    assign rvalid = rvalid_s2;
    assign dout   = dout_s2;
`else
    assign rvalid = rvalid_s1;
    assign dout   = dout_s1;
`endif

endmodule : ram_sp_param

// File: tb/tb_ram_sp_param.sv
// Self-checking bench for ram_sp_param (default 16 x 256 configuration).
// Honours RAM_SP_OUT_REG_EN through ram_sp_pkg::RD_LAT.
module tb_ram_sp_param;
    import ram_sp_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          ready;
    logic [DW-1:0] dout;
    logic          rvalid;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    ram_sp_param #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .CLEAR_VAL (16'h0000)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .be     (be),
        .addr   (addr),
        .din    (din),
        .ready  (ready),
        .dout   (dout),
        .rvalid (rvalid)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [DW-1:0] mem_m [DEPTH];
    int            clr_left = DEPTH;
    logic [DW-1:0] out_q [2] = '{16'h0, 16'h0};   // [0] newest, [1] one edge older
    bit            val_q [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        if (!rst_n) begin
            clr_left = DEPTH;
            out_q    = '{16'h0, 16'h0};
            val_q    = '{1'b0, 1'b0};
        end else begin
            out_q[1] = out_q[0];
            val_q[1] = val_q[0];
            val_q[0] = 1'b0;
            if (clr_left > 0) begin
                mem_m[DEPTH - clr_left] = 16'h0000;
                clr_left--;
            end else if (req) begin
                if (we) begin
                    if (be[0]) mem_m[addr][7:0]  = din[7:0];
                    if (be[1]) mem_m[addr][15:8] = din[15:8];
                end else begin
                    out_q[0] = mem_m[addr];
                    val_q[0] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",  {31'b0, ready},  {31'b0, (clr_left == 0)});
            chk("rvalid", {31'b0, rvalid}, {31'b0, val_q[RD_LAT-1]});
            chk("dout",   {16'b0, dout},   {16'b0, out_q[RD_LAT-1]});
        end
    end

    // ---------------- stimulus ----------------
    // Drive at a negedge, hold through one rising edge, return at next negedge.
    task automatic cyc(input bit r, input bit q, input bit w, input logic [1:0] b,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst_n = r; req = q; we = w; be = b; addr = a; din = d;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
        cyc(1'b1, 1'b1, 1'b1, b, a, d);
    endtask

    task automatic rd_chk(input logic [AW-1:0] a, input logic [DW-1:0] expv, input string nm);
        cyc(1'b1, 1'b1, 1'b0, 2'b00, a, 16'h0000);
        repeat (RD_LAT - 1) idle();
        chk(nm, {16'b0, dout}, {16'b0, expv});
        chk({nm, "_rv"}, {31'b0, rvalid}, 32'd1);
    endtask

    // Runs clear cycles (with random ignored requests) until ready, bounded.
    task automatic wait_clear(output int n);
        n = 0;
        while (!ready && n < 400) begin
            cyc(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 16'($urandom));
            n++;
        end
    endtask

    logic [AW-1:0] b2b_a [4] = '{8'h00, 8'h01, 8'h02, 8'hFF};
    logic [DW-1:0] b2b_d [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hFFFF};

    initial begin
        int n;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready",  {31'b0, ready},  32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_dout",   {16'b0, dout},   32'd0);

        wait_clear(n);
        chk("clear_cycles", n, 32'd256);

        rd_chk(8'h00, 16'h0000, "clr_rd00");
        rd_chk(8'h7F, 16'h0000, "clr_rd7f");
        rd_chk(8'hFF, 16'h0000, "clr_rdff");

        for (int i = 0; i < 4; i++) wr(b2b_a[i], b2b_d[i], 2'b11);
        for (int i = 0; i < 4 + RD_LAT - 1; i++) begin
            int j;
            if (i < 4) cyc(1'b1, 1'b1, 1'b0, 2'b00, b2b_a[i], 16'h0000);
            else idle();
            j = i - (RD_LAT - 1);
            if (j >= 0) begin
                chk("b2b_dout", {16'b0, dout}, {16'b0, b2b_d[j]});
                chk("b2b_rv",   {31'b0, rvalid}, 32'd1);
            end
        end
        idle();

        wr(8'h10, 16'h1234, 2'b11);
        wr(8'h10, 16'hAB56, 2'b01);
        rd_chk(8'h10, 16'h1256, "be01");
        wr(8'h10, 16'hFFFF, 2'b00);
        rd_chk(8'h10, 16'h1256, "be00");

        wr(8'h20, 16'h5A5A, 2'b11);
        rd_chk(8'h20, 16'h5A5A, "wr_then_rd");
        repeat (3) idle();
        chk("dout_hold", {16'b0, dout}, 32'h5A5A);

        // Reset during an in-flight read.
        wr(8'h10, 16'h7777, 2'b11);
        cyc(1'b1, 1'b1, 1'b0, 2'b00, 8'h10, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
        chk("sq_rvalid", {31'b0, rvalid}, 32'd0);
        chk("sq_dout",   {16'b0, dout},   32'd0);
        chk("sq_ready",  {31'b0, ready},  32'd0);

        // Reset again at clear step 100.
        repeat (100) cyc(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 16'($urandom));
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
        wait_clear(n);
        chk("reclear_cycles", n, 32'd256);
        rd_chk(8'h10, 16'h0000, "reclear_rd10");

        // Randomised traffic on a small address window to force reuse.
        for (int i = 0; i < 600; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
                8'($urandom_range(0, 31)), 16'($urandom));
        end
        repeat (3) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ram_sp_param
